// File: rtl/barrett_corr_seq.sv
// Limb-serial final correction for Barrett reduction: repeatedly subtracts q from x
// (at most MAXSUB times) through one shared WBITS-wide subtract-with-borrow slice.
module barrett_corr_seq #(
    parameter int NBITS  = 256,
    parameter int WBITS  = 64,
    parameter int MAXSUB = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NBITS-1:0]               x,
    input  logic [NBITS-1:0]               q,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NBITS-1:0]               y,
    output logic [$clog2(MAXSUB+1)-1:0]    nsub
);

    localparam int LIMBS = NBITS / WBITS;
    localparam int NSW   = $clog2(MAXSUB + 1);
    localparam int LW    = (LIMBS > 1) ? $clog2(LIMBS) : 1;

    if (NBITS % WBITS != 0) begin : g_bad_limb_width
        $error("barrett_corr_seq: NBITS must be a multiple of WBITS");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_CHK,
        S_DONE
    } state_t;

    state_t             state_q,     state_d;
    logic [NBITS-1:0]   xr_q,        xr_d;
    logic [NBITS-1:0]   qr_q,        qr_d;
    logic [NBITS-1:0]   dr_q,        dr_d;
    logic               borrow_q,    borrow_d;
    logic [LW-1:0]      limb_q,      limb_d;
    logic [NSW-1:0]     pass_q,      pass_d;
    logic [NBITS-1:0]   y_q,         y_d;
    logic [NSW-1:0]     nsub_q,      nsub_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q,  in_ready_d;

    logic [WBITS-1:0]   a_limb;
    logic [WBITS-1:0]   b_limb;
    logic [WBITS:0]     diff;
    logic [NSW-1:0]     pass_inc;
    logic               last_pass;

    always_comb begin
        state_d     = state_q;
        xr_d        = xr_q;
        qr_d        = qr_q;
        dr_d        = dr_q;
        borrow_d    = borrow_q;
        limb_d      = limb_q;
        pass_d      = pass_q;
        y_d         = y_q;
        nsub_d      = nsub_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        // The shared slice: one limb of x_r - q_r - borrow, borrow out in bit WBITS.
        a_limb    = xr_q[limb_q*WBITS +: WBITS];
        b_limb    = qr_q[limb_q*WBITS +: WBITS];
        diff      = {1'b0, a_limb} - {1'b0, b_limb} - {{WBITS{1'b0}}, borrow_q};
        pass_inc  = pass_q + NSW'(1);
        last_pass = (pass_inc == NSW'(MAXSUB));

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    xr_d       = x;
                    qr_d       = q;
                    pass_d     = '0;
                    limb_d     = '0;
                    borrow_d   = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = S_SUB;
                end
            end
            S_SUB: begin
                dr_d[limb_q*WBITS +: WBITS] = diff[WBITS-1:0];
                borrow_d = diff[WBITS];
                if (limb_q == LW'(LIMBS - 1)) begin
                    state_d = S_CHK;
                end else begin
                    limb_d = limb_q + LW'(1);
                end
            end
            S_CHK: begin
                // A final borrow means x_r < q_r, so the (wrapped) difference is discarded.
                if (!borrow_q) begin
                    xr_d   = dr_q;
                    pass_d = pass_inc;
                end
                if (borrow_q || last_pass) begin
                    y_d         = borrow_q ? xr_q : dr_q;
                    nsub_d      = borrow_q ? pass_q : pass_inc;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    limb_d   = '0;
                    borrow_d = 1'b0;
                    state_d  = S_SUB;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            xr_q        <= '0;
            qr_q        <= '0;
            dr_q        <= '0;
            borrow_q    <= 1'b0;
            limb_q      <= '0;
            pass_q      <= '0;
            y_q         <= '0;
            nsub_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            xr_q        <= xr_d;
            qr_q        <= qr_d;
            dr_q        <= dr_d;
            borrow_q    <= borrow_d;
            limb_q      <= limb_d;
            pass_q      <= pass_d;
            y_q         <= y_d;
            nsub_q      <= nsub_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign nsub      = nsub_q;

endmodule

// File: tb/tb_barrett_corr_seq.sv
// Scoreboard bench for barrett_corr_seq at NBITS=16, WBITS=4, MAXSUB=2.
module tb_barrett_corr_seq;

    localparam int NB = 16;
    localparam int MS = 2;
    localparam int LIMBS = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] x;
    logic [NB-1:0] q;
    logic          out_valid;
    logic          out_ready;
    logic [NB-1:0] y;
    logic [1:0]    nsub;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NB-1:0] y;
        logic [1:0]    n;
        int            lat;
    } exp_t;

    exp_t sb[$];

    barrett_corr_seq #(
        .NBITS (NB),
        .WBITS (4),
        .MAXSUB(MS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .q        (q),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .nsub     (nsub)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: subtract while x >= q, up to MS times; p counts passes executed.
    task automatic model(input int xv, input int qv, output int ey, output int en, output int ep);
        ey = xv;
        en = 0;
        ep = 0;
        for (int i = 0; i < MS; i++) begin
            ep++;
            if (ey >= qv) begin
                ey = ey - qv;
                en++;
            end else begin
                break;
            end
        end
    endtask

    task automatic run_case(input logic [NB-1:0] xv, input logic [NB-1:0] qv,
                            input logic [NB-1:0] ey, input logic [1:0] en,
                            input int ep, input int hold);
        exp_t e;
        int k;
        logic [NB-1:0] ys;
        logic [1:0] ns;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        x = xv;
        q = qv;
        in_valid = 1'b1;
        out_ready = 1'b0;
        e.y = ey;
        e.n = en;
        e.lat = 1 + ep * (LIMBS + 1);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        x = '0;
        q = '0;
        k = 1;
        chk("busy_in_ready", in_ready, 0);
        while (!out_valid && k < 100) begin
            if (k == 2 && hold > 0) begin
                in_valid = 1'b1;
                x = 16'hFFFF;
                q = 16'h0001;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        chk("out_valid_timeout", out_valid, 1);
        e = sb.pop_front();
        chk("y", y, e.y);
        chk("nsub", nsub, e.n);
        chk("latency", k, e.lat);
        ys = y;
        ns = nsub;
        for (int i = 0; i < hold; i++) begin
            in_valid = (i == 0);
            x = 16'h0003;
            q = 16'h0001;
            @(negedge clk);
            chk("hold_y", y, ys);
            chk("hold_nsub", nsub, ns);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        int ry, rn, rp, rq, rx, hi;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x = '0;
        q = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_nsub", nsub, 0);
        rst_n = 1'b1;

        run_case(16'h0100, 16'h1234, 16'h0100, 2'd0, 1, 0);
        run_case(16'h1240, 16'h1234, 16'h000C, 2'd1, 2, 0);
        run_case(16'h246D, 16'h1234, 16'h0005, 2'd2, 2, 0);
        run_case(16'hFFF0, 16'hFFF0, 16'h0000, 2'd1, 2, 0);
        run_case(16'h1000, 16'h0FFF, 16'h0001, 2'd1, 2, 0);
        run_case(16'h0000, 16'h0001, 16'h0000, 2'd0, 1, 0);
        run_case(16'hFFFF, 16'h1000, 16'hDFFF, 2'd2, 2, 0);
        run_case(16'h246D, 16'h1234, 16'h0005, 2'd2, 2, 3);

        for (int j = 0; j < 6; j++) begin
            rq = $urandom_range(1, 16'hFFFF);
            hi = (3 * rq - 1 > 16'hFFFF) ? 16'hFFFF : 3 * rq - 1;
            rx = $urandom_range(0, hi);
            model(rx, rq, ry, rn, rp);
            run_case(NB'(rx), NB'(rq), NB'(ry), 2'(rn), rp, j % 2);
        end

        // Abort mid-pass: reset wipes the in-flight result.
        @(negedge clk);
        x = 16'h246D;
        q = 16'h1234;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_y", y, 0);
        chk("abort_nsub", nsub, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_case(16'h0100, 16'h1234, 16'h0100, 2'd0, 1, 0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
